// File: rtl/riscv_irq_sync_mc_if.sv
// Core-facing interrupt request / acknowledge handshake of the multi-channel irq synchroniser.
interface riscv_irq_sync_mc_if;
  logic       irq_o;
  logic [4:0] irq_id_o;
  logic       irq_sec_o;
  logic       irq_ack_i;
  logic [4:0] irq_id_i;

  modport master (
    output irq_o,
    output irq_id_o,
    output irq_sec_o,
    input  irq_ack_i,
    input  irq_id_i
  );

  modport slave (
    input  irq_o,
    input  irq_id_o,
    input  irq_sec_o,
    output irq_ack_i,
    output irq_id_i
  );
endinterface

// File: rtl/riscv_irq_sync_mc.sv
// Multi-channel interrupt synchroniser: per-channel sync chain, edge/level pending state,
// fixed-priority selection and a registered request/ID towards the core.
module riscv_irq_sync_mc #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ID_BASE     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  edge_mode_i,
  input  logic [NUM_IRQ-1:0]  irq_en_i,
  output logic [NUM_IRQ-1:0]  irq_sync_o,
  output logic [NUM_IRQ-1:0]  irq_pend_o,
  riscv_irq_sync_mc_if.master core
);

  localparam int unsigned IDW = 5;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic               irq_q;
  logic [IDW-1:0]     irq_id_q;

  logic [NUM_IRQ-1:0] sync_last;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] pend_next;
  logic [NUM_IRQ-1:0] cand;
  logic               found;
  logic [IDW-1:0]     win_id;

  // Synchroniser chain, history flop and last-seen mode per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
      mode_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      mode_q <= edge_mode_i;
    end
  end

  // Pending update and lowest-index winner among enabled channels
  always_comb begin
    sync_last = sync_q[SYNC_STAGES-1];
    rise      = sync_last & ~hist_q;
    ack_hit   = '0;
    pend_next = '0;
    found     = 1'b0;
    win_id    = irq_id_q;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      ack_hit[i] = core.irq_ack_i && (core.irq_id_i == IDW'(ID_BASE + 32'(i)));
      if (edge_mode_i[i] != mode_q[i]) begin
        pend_next[i] = 1'b0;
      end else if (edge_mode_i[i]) begin
        // A fresh edge beats a simultaneous ack so it is never lost
        pend_next[i] = rise[i] | (pend_q[i] & ~ack_hit[i]);
      end else begin
        pend_next[i] = sync_last[i];
      end
    end
    cand = pend_next & irq_en_i;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (cand[i] && !found) begin
        found  = 1'b1;
        win_id = IDW'(ID_BASE + 32'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      pend_q   <= pend_next;
      irq_q    <= found;
      irq_id_q <= win_id;
    end
  end

  assign irq_sync_o     = sync_q[SYNC_STAGES-1];
  assign irq_pend_o     = pend_q;
  assign core.irq_o     = irq_q;
  assign core.irq_id_o  = irq_id_q;
  assign core.irq_sec_o = 1'b1;

endmodule

// File: tb/tb_riscv_irq_sync_mc.sv
// Bench for riscv_irq_sync_mc: directed scenarios plus random traffic against a delay-line reference model.
module tb_riscv_irq_sync_mc;
  localparam int N = 4;
  localparam int S = 2;
  localparam int B = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq, mode, en, sync, pend;

  int vectors = 0;
  int miscompares = 0;

  riscv_irq_sync_mc_if core_if();

  riscv_irq_sync_mc #(.NUM_IRQ(N), .SYNC_STAGES(S), .ID_BASE(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq),
    .edge_mode_i (mode),
    .irq_en_i    (en),
    .irq_sync_o  (sync),
    .irq_pend_o  (pend),
    .core        (core_if.master)
  );

  always #5 clk = ~clk;

  // Reference: samp[k] is the raw input sampled k edges ago
  logic [N-1:0] samp [S+1];
  logic [N-1:0] m_pend, m_prev_mode;
  logic         m_irq;
  logic [4:0]   m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= S; k++) samp[k] = '0;
    m_pend = '0; m_prev_mode = '0; m_irq = 1'b0; m_id = '0;
  endtask

  // Advance one edge in model and DUT, then compare everything visible
  task automatic step();
    logic [N-1:0] nxt, cand;
    logic         rise;
    int           c, low;
    nxt = m_pend;
    for (int i = 0; i < N; i++) begin
      rise = samp[S-1][i] & ~samp[S][i];
      if (mode[i] !== m_prev_mode[i])  nxt[i] = 1'b0;
      else if (mode[i])                nxt[i] = rise | (m_pend[i] & !(core_if.irq_ack_i && int'(core_if.irq_id_i) == B + i));
      else                             nxt[i] = samp[S-1][i];
    end
    cand = nxt & en;
    c    = int'(cand);
    if (c != 0) begin
      low   = $clog2(c & -c);
      m_irq = 1'b1;
      m_id  = 5'(B + low);
    end else begin
      m_irq = 1'b0;
    end
    for (int k = S; k > 0; k--) samp[k] = samp[k-1];
    samp[0]     = irq;
    m_prev_mode = mode;
    m_pend      = nxt;
    @(posedge clk);
    #1;
    chk("irq_o",     32'(core_if.irq_o),     32'(m_irq));
    chk("irq_id_o",  32'(core_if.irq_id_o),  32'(m_id));
    chk("irq_pend",  32'(pend),              32'(m_pend));
    chk("irq_sync",  32'(sync),              32'(samp[S-1]));
    chk("irq_sec_o", 32'(core_if.irq_sec_o), 32'(1));
  endtask

  task automatic ack(input int id);
    core_if.irq_ack_i = 1'b1;
    core_if.irq_id_i  = 5'(id);
    step();
    core_if.irq_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pend_snap;
    rst_n = 1'b0; irq = '0; mode = 4'hF; en = 4'hF;
    core_if.irq_ack_i = 1'b0; core_if.irq_id_i = '0;
    model_reset();
    #12;
    chk("rst_irq_o",  32'(core_if.irq_o),     32'(0));
    chk("rst_id",     32'(core_if.irq_id_o),  32'(0));
    chk("rst_pend",   32'(pend),              32'(0));
    chk("rst_sync",   32'(sync),              32'(0));
    chk("rst_sec",    32'(core_if.irq_sec_o), 32'(1));
    rst_n = 1'b1;
    step(); step();

    // Basic edge request on channel 2
    irq[2] = 1'b1; step(); step();
    irq[2] = 1'b0; step();
    chk("edge_req_irq", 32'(core_if.irq_o),    32'(1));
    chk("edge_req_id",  32'(core_if.irq_id_o), 32'(18));
    step(); step();
    chk("edge_hold_irq", 32'(core_if.irq_o), 32'(1));
    ack(18);
    chk("edge_ack_irq", 32'(core_if.irq_o), 32'(0));
    step();

    // Priority and zero-bubble handover
    irq = 4'b1010; step(); step(); step();
    irq = '0;
    chk("prio_id", 32'(core_if.irq_id_o), 32'(17));
    ack(17);
    chk("handover_irq", 32'(core_if.irq_o),    32'(1));
    chk("handover_id",  32'(core_if.irq_id_o), 32'(19));
    ack(19);
    chk("drain_irq", 32'(core_if.irq_o),    32'(0));
    chk("drain_id",  32'(core_if.irq_id_o), 32'(19));
    step();

    // Level mode on channel 0
    mode = 4'b1110; step();
    irq[0] = 1'b1; step(); step(); step();
    chk("level_id", 32'(core_if.irq_id_o), 32'(16));
    ack(16);
    chk("level_ack_irq", 32'(core_if.irq_o), 32'(1));
    irq[0] = 1'b0; step(); step(); step();
    chk("level_rel_irq", 32'(core_if.irq_o), 32'(0));
    mode = 4'hF; step(); step();

    // Ack collides with a new rise on channel 2, then an unmatched ack
    irq[2] = 1'b1; step(); step();
    irq[2] = 1'b0; step();
    irq[2] = 1'b1; step(); step();
    ack(18);
    chk("coll_pend2", 32'(pend[2]),         32'(1));
    chk("coll_irq",   32'(core_if.irq_o),   32'(1));
    pend_snap = pend;
    ack(30);
    chk("badid_pend", 32'(pend),              32'(pend_snap));
    chk("badid_id",   32'(core_if.irq_id_o),  32'(18));
    ack(18);
    irq[2] = 1'b0; step(); step(); step();

    // Masking keeps pending until re-enabled
    en = 4'b0111;
    irq[3] = 1'b1; step(); step();
    irq[3] = 1'b0; step(); step();
    chk("mask_pend3", 32'(pend[3]),       32'(1));
    chk("mask_irq",   32'(core_if.irq_o), 32'(0));
    en = 4'hF; step();
    chk("unmask_irq", 32'(core_if.irq_o),    32'(1));
    chk("unmask_id",  32'(core_if.irq_id_o), 32'(19));
    ack(19);

    // Reset mid-operation with channel 0 held high
    irq[0] = 1'b1; step(); step(); step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_irq",  32'(core_if.irq_o),     32'(0));
    chk("mid_rst_id",   32'(core_if.irq_id_o),  32'(0));
    chk("mid_rst_pend", 32'(pend),              32'(0));
    chk("mid_rst_sync", 32'(sync),              32'(0));
    chk("mid_rst_sec",  32'(core_if.irq_sec_o), 32'(1));
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst_irq", 32'(core_if.irq_o),    32'(1));
    chk("post_rst_id",  32'(core_if.irq_id_o), 32'(16));
    irq[0] = 1'b0;
    ack(16);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      irq = N'($urandom);
      if ($urandom_range(0, 7) == 0)  en   = N'($urandom);
      if ($urandom_range(0, 39) == 0) mode = N'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) ack(int'($urandom_range(14, 23)));
        else                           ack(int'(m_id));
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
